// File: rtl/wb_bus_arbiter.sv
// Purpose: two-master pipelined Wishbone arbiter (m0 = instruction bus, m1 = data bus) sharing one slave port.
// Latency: request to s_stb is 1 cycle from IDLE; slave acks and read data return combinationally to the owner.
// Backpressure: the owner sees s_stall, plus a stall when MAX_OUT requests are unacked; a non-owner always sees stall=1.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), asynchronous active-low reset
//   m0_* / m1_*               master-side Wishbone: adr, dat_m, we, sel, cyc, stb in; ack, stall, dat_s out
//   s_*                       shared slave port: adr, dat_m, we, sel, cyc, stb out; ack, stall, dat_s in
//   grant[1:0]                registered one-hot owner: [0] m0, [1] m1, 00 idle
//   busy                      outstanding request count is non-zero
//
// Build option: define WB_ARB_RR_EN to break IDLE ties round-robin. A last-owner flop resets to m1,
// and the tie goes to the master not served last. Otherwise ties use fixed priority PRIO_M1.
module wb_bus_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 3,
    parameter int PRIO_M1 = 1,
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int SEL_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_dat_m,
    input  logic             m0_we,
    input  logic [SEL_W-1:0] m0_sel,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    output logic             m0_ack,
    output logic             m0_stall,
    output logic [DAT_W-1:0] m0_dat_s,

    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_dat_m,
    input  logic             m1_we,
    input  logic [SEL_W-1:0] m1_sel,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    output logic             m1_ack,
    output logic             m1_stall,
    output logic [DAT_W-1:0] m1_dat_s,

    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_m,
    output logic             s_we,
    output logic [SEL_W-1:0] s_sel,
    output logic             s_cyc,
    output logic             s_stb,
    input  logic             s_ack,
    input  logic             s_stall,
    input  logic [DAT_W-1:0] s_dat_s,

    output logic [1:0]       grant,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       grant_q;

    logic own0;
    logic own1;
    logic req0;
    logic req1;
    logic tie_m1;
    logic own_cyc;
    logic own_stb;
    logic cnt_full;
    logic issue;
    logic ack_dec;

    assign own0 = (state_q == ST_OWN0);
    assign own1 = (state_q == ST_OWN1);
    assign req0 = m0_cyc & m0_stb;
    assign req1 = m1_cyc & m1_stb;

`ifdef WB_ARB_RR_EN
    // Remembers which master was granted last, so the next tie goes to the other one.
    logic last_m1_q;

    assign tie_m1 = ~last_m1_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_m1_q <= 1'b1;
        end else if (state_q == ST_IDLE && state_nxt != ST_IDLE) begin
            last_m1_q <= (state_nxt == ST_OWN1);
        end
    end
`else
    assign tie_m1 = (PRIO_M1 != 0);
`endif

    // Owner's bus-cycle and strobe; both are zero while idle.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        if (own0) begin
            own_cyc = m0_cyc;
            own_stb = m0_stb;
        end else if (own1) begin
            own_cyc = m1_cyc;
            own_stb = m1_stb;
        end
    end

    assign cnt_full = (cnt_q == MAX_CNT);
    assign issue    = s_stb & ~s_stall;
    // An ack with nothing outstanding is ignored, so the counter cannot underflow.
    assign ack_dec  = s_ack & (cnt_q != '0);

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_nxt = tie_m1 ? ST_OWN1 : ST_OWN0;
                end else if (req1) begin
                    state_nxt = ST_OWN1;
                end else if (req0) begin
                    state_nxt = ST_OWN0;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_cyc) begin
                    // End of cycle, or abort with requests in flight.
                    // Any late acks are dropped, so the count restarts from zero.
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (issue && !ack_dec) begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end else if (!issue && ack_dec) begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            grant_q <= {state_nxt == ST_OWN1, state_nxt == ST_OWN0};
        end
    end

    // Slave port mirrors the owner's request fields; it is driven to zero while idle.
    always_comb begin
        s_adr   = '0;
        s_dat_m = '0;
        s_we    = 1'b0;
        s_sel   = '0;
        if (own1) begin
            s_adr   = m1_adr;
            s_dat_m = m1_dat_m;
            s_we    = m1_we;
            s_sel   = m1_sel;
        end else if (own0) begin
            s_adr   = m0_adr;
            s_dat_m = m0_dat_m;
            s_we    = m0_we;
            s_sel   = m0_sel;
        end
    end

    assign s_cyc = own_cyc;
    assign s_stb = own_cyc & own_stb & ~cnt_full;

    assign m0_stall = ~own0 | s_stall | cnt_full;
    assign m1_stall = ~own1 | s_stall | cnt_full;
    assign m0_ack   = own0 & s_ack;
    assign m1_ack   = own1 & s_ack;
    assign m0_dat_s = s_dat_s;
    assign m1_dat_s = s_dat_s;

    assign grant = grant_q;
    assign busy  = (cnt_q != '0);

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Purpose: self-checking bench for wb_bus_arbiter using per-cycle vector rows plus hand-written tie and reset sequences.
// Latency: each row's inputs are applied after a falling edge; outputs are sampled 2 time units later, before the next rising edge.
// Backpressure: the slave's ack and stall are scripted per row; masters hold stb until the model says the request was accepted.
module tb_wb_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m0_adr, m0_dat_m, m0_dat_s, m1_adr, m1_dat_m, m1_dat_s;
    logic [31:0] s_adr, s_dat_m, s_dat_s;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_stall;
    logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_stall;
    logic        s_we, s_cyc, s_stb, s_ack, s_stall;
    logic [1:0]  grant;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

`ifdef WB_ARB_RR_EN
    localparam logic TIE2_M1 = 1'b0;
`else
    localparam logic TIE2_M1 = 1'b1;
`endif

    always #5 clk_i = ~clk_i;

    wb_bus_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr(m0_adr), .m0_dat_m(m0_dat_m), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_ack(m0_ack), .m0_stall(m0_stall), .m0_dat_s(m0_dat_s),
        .m1_adr(m1_adr), .m1_dat_m(m1_dat_m), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_ack(m1_ack), .m1_stall(m1_stall), .m1_dat_s(m1_dat_s),
        .s_adr(s_adr), .s_dat_m(s_dat_m), .s_we(s_we), .s_sel(s_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_ack(s_ack), .s_stall(s_stall), .s_dat_s(s_dat_s),
        .grant(grant), .busy(busy)
    );

    // Row fields:
    //   in  = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall}
    //   sb  = {s_cyc, s_stb, s_we}
    //   adr = expected low 12 bits of s_adr (upper bits are zero)
    //   mo  = {m0_ack, m1_ack, m0_stall, m1_stall, busy}
    typedef struct {
        string      name;
        logic [5:0] in;
        logic [1:0] g;
        logic [2:0] sb;
        logic [11:0] adr;
        logic [4:0] mo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input logic [5:0] in, input logic [1:0] g,
                                input logic [2:0] sb, input logic [11:0] adr, input logic [4:0] mo);
        vec_t v;
        v.name = nm; v.in = in; v.g = g; v.sb = sb; v.adr = adr; v.mo = mo;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic [5:0] in);
        @(negedge clk_i);
        {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall} = in;
        #2;
    endtask

    initial begin
        // Scenario A: m0 performs a single read.
        add("r0",  6'b000000, 2'b00, 3'b000, 12'h000, 5'b00110);
        add("r1",  6'b110000, 2'b00, 3'b000, 12'h000, 5'b00110);
        add("r2",  6'b110000, 2'b01, 3'b110, 12'h100, 5'b00010);
        add("r3",  6'b100000, 2'b01, 3'b100, 12'h100, 5'b00011);
        add("r4",  6'b100010, 2'b01, 3'b100, 12'h100, 5'b10011);
        add("r5",  6'b000000, 2'b01, 3'b000, 12'h100, 5'b00010);
        add("r6",  6'b000000, 2'b00, 3'b000, 12'h000, 5'b00110);
        // Scenario B: tie goes to m1; m0 waits through one IDLE cycle.
        add("r7",  6'b111100, 2'b00, 3'b000, 12'h000, 5'b00110);
        add("r8",  6'b111100, 2'b10, 3'b111, 12'h200, 5'b00100);
        add("r9",  6'b111010, 2'b10, 3'b101, 12'h200, 5'b01101);
        add("r10", 6'b110000, 2'b10, 3'b001, 12'h200, 5'b00100);
        add("r11", 6'b110000, 2'b00, 3'b000, 12'h000, 5'b00110);
        add("r12", 6'b110000, 2'b01, 3'b110, 12'h100, 5'b00010);
        add("r13", 6'b100010, 2'b01, 3'b100, 12'h100, 5'b10011);
        add("r14", 6'b000000, 2'b01, 3'b000, 12'h100, 5'b00010);
        // Scenario C: m1 issues 6 pipelined writes; the outstanding limit of 4 applies.
        add("p0",  6'b001100, 2'b00, 3'b000, 12'h000, 5'b00110);
        add("p1",  6'b001100, 2'b10, 3'b111, 12'h200, 5'b00100);
        add("p2",  6'b001100, 2'b10, 3'b111, 12'h200, 5'b00101);
        add("p3",  6'b001100, 2'b10, 3'b111, 12'h200, 5'b00101);
        add("p4",  6'b001100, 2'b10, 3'b111, 12'h200, 5'b00101);
        add("p5",  6'b001100, 2'b10, 3'b101, 12'h200, 5'b00111);
        add("p6",  6'b001110, 2'b10, 3'b101, 12'h200, 5'b01111);
        add("p7",  6'b001100, 2'b10, 3'b111, 12'h200, 5'b00101);
        add("p8",  6'b001110, 2'b10, 3'b101, 12'h200, 5'b01111);
        add("p9",  6'b001100, 2'b10, 3'b111, 12'h200, 5'b00101);
        add("p10", 6'b001010, 2'b10, 3'b101, 12'h200, 5'b01111);
        add("p11", 6'b001010, 2'b10, 3'b101, 12'h200, 5'b01101);
        add("p12", 6'b001010, 2'b10, 3'b101, 12'h200, 5'b01101);
        add("p13", 6'b001010, 2'b10, 3'b101, 12'h200, 5'b01101);
        add("p14", 6'b001000, 2'b10, 3'b101, 12'h200, 5'b00100);
        // Issue and ack in the same cycle at count 2, then an ack at count 0.
        add("p15", 6'b001100, 2'b10, 3'b111, 12'h200, 5'b00100);
        add("p16", 6'b001100, 2'b10, 3'b111, 12'h200, 5'b00101);
        add("p17", 6'b001110, 2'b10, 3'b111, 12'h200, 5'b01101);
        add("p18", 6'b001010, 2'b10, 3'b101, 12'h200, 5'b01101);
        add("p19", 6'b001010, 2'b10, 3'b101, 12'h200, 5'b01101);
        add("p20", 6'b001010, 2'b10, 3'b101, 12'h200, 5'b01100);
        add("p21", 6'b001000, 2'b10, 3'b101, 12'h200, 5'b00100);
        add("p22", 6'b000000, 2'b10, 3'b001, 12'h200, 5'b00100);
        // Scenario D: m0 aborts with 3 outstanding; a stray ack then arrives while idle.
        add("a0",  6'b110000, 2'b00, 3'b000, 12'h000, 5'b00110);
        add("a1",  6'b110000, 2'b01, 3'b110, 12'h100, 5'b00010);
        add("a2",  6'b110001, 2'b01, 3'b110, 12'h100, 5'b00111);
        add("a3",  6'b110000, 2'b01, 3'b110, 12'h100, 5'b00011);
        add("a4",  6'b110000, 2'b01, 3'b110, 12'h100, 5'b00011);
        add("a5",  6'b000000, 2'b01, 3'b000, 12'h100, 5'b00011);
        add("a6",  6'b000010, 2'b00, 3'b000, 12'h000, 5'b00110);
        add("a7",  6'b000000, 2'b00, 3'b000, 12'h000, 5'b00110);

        m0_adr = 32'h100; m0_dat_m = 32'h0;        m0_we = 1'b0; m0_sel = 4'hf;
        m1_adr = 32'h200; m1_dat_m = 32'hcafe0001; m1_we = 1'b1; m1_sel = 4'h3;
        s_dat_s = 32'h5a5a1234;
        {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall} = 6'b0;
        rst_i = 1'b0;
        #1;
        chk("reset.grant", 32'(grant), 32'h0);
        chk("reset.s_cyc_stb_we", 32'({s_cyc, s_stb, s_we}), 32'h0);
        chk("reset.ack_stall_busy", 32'({m0_ack, m1_ack, m0_stall, m1_stall, busy}), 32'b00110);
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            chk({vecs[i].name, ".grant"}, 32'(grant), 32'(vecs[i].g));
            chk({vecs[i].name, ".s_cyc_stb_we"}, 32'({s_cyc, s_stb, s_we}), 32'(vecs[i].sb));
            chk({vecs[i].name, ".s_adr"}, s_adr, 32'(vecs[i].adr));
            chk({vecs[i].name, ".ack_stall_busy"}, 32'({m0_ack, m1_ack, m0_stall, m1_stall, busy}), 32'(vecs[i].mo));
        end
        chk("m1_dat_s", m1_dat_s, 32'h5a5a1234);

        // Tie sequence. The last owner is m0, so the first tie goes to m1 in both builds.
        // After m1 is served, the second tie differs by build.
        drive(6'b111100);
        chk("tie1.idle", 32'(grant), 32'h0);
        drive(6'b000000);
        chk("tie1.grant", 32'(grant), 32'b10);
        drive(6'b111100);
        chk("tie2.idle", 32'(grant), 32'h0);
        // The winner drops cyc while the loser keeps requesting.
        drive(TIE2_M1 ? 6'b110000 : 6'b001100);
        chk("tie2.grant", 32'(grant), TIE2_M1 ? 32'b10 : 32'b01);
        drive(TIE2_M1 ? 6'b110000 : 6'b001100);
        chk("tie2.gap_idle", 32'(grant), 32'h0);
        drive(TIE2_M1 ? 6'b110000 : 6'b001100);
        chk("tie2.loser_grant", 32'(grant), TIE2_M1 ? 32'b01 : 32'b10);
        drive(6'b000000);
        drive(6'b000000);
        chk("tie2.end_idle", 32'({grant, busy}), 32'h0);

        // Asynchronous reset in the middle of an m1 burst, with 2 requests outstanding.
        drive(6'b001100);
        drive(6'b001100);
        drive(6'b001100);
        drive(6'b001000);
        chk("rst_mid.pre", 32'({grant, busy}), 32'b101);
        s_ack = 1'b1;
        rst_i = 1'b0;
        #1;
        chk("rst_mid.grant", 32'(grant), 32'h0);
        chk("rst_mid.s_cyc_stb", 32'({s_cyc, s_stb}), 32'h0);
        chk("rst_mid.ack_stall_busy", 32'({m0_ack, m1_ack, m0_stall, m1_stall, busy}), 32'b00110);
        @(negedge clk_i);
        {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall} = 6'b0;
        rst_i = 1'b1;
        drive(6'b000000);
        chk("rst_mid.after", 32'({grant, busy, s_cyc}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
